// File: rtl/fifo_fill_ctrl_pkg.sv
// Shared state type, default sizes and small helpers for the MAC input-FIFO loader.
package fill_pkg;
    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_BYTES_PER_WORD = 8;
    localparam int unsigned DEF_NUM_ROWS       = 9;
    localparam int unsigned DEF_ADDR_WIDTH     = 32;
    localparam int unsigned STALL_CNT_W        = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE,
        DONE
    } fill_state_e;

    // Counter width that stays legal when a range collapses to a single entry.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fifo_fill_ctrl_word_serializer.sv
// Holds one memory word and presents it a byte at a time, least significant byte first.
module word_serializer
    import fill_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 load,
    input  logic [DATA_WIDTH*BYTES_PER_WORD-1:0] word,
    input  logic                                 advance,
    output logic [DATA_WIDTH-1:0]                byte_out,
    output logic                                 last
);
    localparam int unsigned IDX_W = idx_width(BYTES_PER_WORD);

    logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0] word_q, word_d;
    logic [IDX_W-1:0]                          idx_q, idx_d;

    assign last     = (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    assign byte_out = word_q[idx_q];

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load) begin
            word_d = word;
            idx_d  = '0;
        end else if (advance && !last) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end
endmodule

// File: rtl/fifo_fill_ctrl.sv
// Loads the MAC input FIFO bank: one memory read per row, then 8 byte writes into that row's FIFO.
// Optional stall_cycles output and counter when FIFO_FILL_STALL_CNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | read request on the bus, held while waitrequest
// WAIT  | request accepted, waiting for readdatavalid
// WRITE | pushing the latched word byte by byte into FIFO[row]
// DONE  | one-cycle completion pulse
module fifo_fill_ctrl
    import fill_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int unsigned NUM_ROWS       = DEF_NUM_ROWS,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned BASE_ADDR      = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    output logic [ADDR_WIDTH-1:0]                mem_address,
    output logic                                 mem_read,
    input  logic                                 mem_waitrequest,
    input  logic [DATA_WIDTH*BYTES_PER_WORD-1:0] mem_readdata,
    input  logic                                 mem_readdatavalid,
    output logic [NUM_ROWS-1:0]                  fifo_wren,
    output logic [DATA_WIDTH-1:0]                fifo_wdata,
    input  logic [NUM_ROWS-1:0]                  fifo_full,
    output logic                                 busy,
    output logic                                 done
`ifdef FIFO_FILL_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]               stall_cycles
`endif
);
    localparam int unsigned ROW_W = idx_width(NUM_ROWS);

    fill_state_e          state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 ser_load, ser_adv, ser_last, wr_en;
    logic [DATA_WIDTH-1:0] ser_byte;

    word_serializer #(
        .DATA_WIDTH     (DATA_WIDTH),
        .BYTES_PER_WORD (BYTES_PER_WORD)
    ) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ser_load),
        .word     (mem_readdata),
        .advance  (ser_adv),
        .byte_out (ser_byte),
        .last     (ser_last)
    );

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        mem_read = 1'b0;
        ser_load = 1'b0;
        ser_adv  = 1'b0;
        wr_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy    = 1'b1;
                    row_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                if (!mem_waitrequest) state_d = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (mem_readdatavalid) begin
                    ser_load = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                busy = 1'b1;
                // A full FIFO simply freezes the byte index; nothing is dropped.
                if (!fifo_full[row_q]) begin
                    wr_en   = 1'b1;
                    ser_adv = 1'b1;
                    if (ser_last) begin
                        if (row_q == ROW_W'(NUM_ROWS - 1)) begin
                            state_d = DONE;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = REQ;
                        end
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    assign mem_address = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(row_q);
    assign fifo_wren   = wr_en ? (NUM_ROWS'(1) << row_q) : '0;
    assign fifo_wdata  = wr_en ? ser_byte : '0;

`ifdef FIFO_FILL_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start) begin
            stall_d = '0;
        end else if (((state_q == REQ && mem_waitrequest) ||
                      (state_q == WRITE && fifo_full[row_q])) && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Randomised bench for fifo_fill_ctrl: memory responder, FIFO-full driver and byte scoreboard.
module tb_fifo_fill_ctrl;
    import fill_pkg::*;

    localparam int DW   = 8;
    localparam int BPW  = 8;
    localparam int NR   = 9;
    localparam int AW   = 32;
    localparam int BASE = 0;
    localparam int WW   = DW * BPW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_waitrequest;
    logic [WW-1:0] mem_readdata;
    logic          mem_readdatavalid;
    logic [NR-1:0] fifo_wren;
    logic [DW-1:0] fifo_wdata;
    logic [NR-1:0] fifo_full;
    logic          busy;
    logic          done;
`ifdef FIFO_FILL_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cycles;
`endif

    fifo_fill_ctrl #(
        .DATA_WIDTH(DW), .BYTES_PER_WORD(BPW), .NUM_ROWS(NR), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
        .fifo_wren(fifo_wren), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
        .busy(busy), .done(done)
`ifdef FIFO_FILL_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference state: memory image and bytes actually received by each FIFO
    logic [WW-1:0] mem [NR];
    logic [DW-1:0] rx  [NR][$];

    int cyc = 0;
    int start_cyc, done_cyc, busy_cnt, reads, exp_extra, exp_stalls;
    bit done_seen, fill_active;

    int ws_max, lat_max, full_pct, spur_pct, dir_wait_row, dir_full_left;
    bit req_seen, prev_wait, legal;
    int wait_left, rsp_cnt, rsp_row, active_row = -1, pend_row = -1;
    logic [AW-1:0] req_addr;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            req_seen = 0; prev_wait = 0; wait_left = 0; rsp_cnt = 0;
            active_row = -1; pend_row = -1;
            mem_waitrequest = 0; mem_readdatavalid = 0; fifo_full = '0;
            for (int r = 0; r < NR; r++) rx[r].delete();
        end else begin
            if (pend_row >= 0) begin
                active_row = pend_row;
                pend_row   = -1;
            end
            mem_readdatavalid = 0;
            mem_readdata      = WW'({$urandom, $urandom});
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    mem_readdatavalid = 1;
                    mem_readdata      = mem[rsp_row];
                    pend_row          = rsp_row;
                end
            end else if (spur_pct > 0 && $urandom_range(99) < spur_pct) begin
                mem_readdatavalid = 1;
            end

            if (prev_wait) begin
                check("req_hold_read", 64'(mem_read), 64'(1));
                check("req_hold_addr", 64'(mem_address), 64'(req_addr));
            end
            prev_wait = 0;
            if (mem_read) begin
                if (!req_seen) begin
                    req_seen = 1;
                    reads++;
                    req_addr = mem_address;
                    check("req_addr", 64'(mem_address), 64'(BASE + reads - 1));
                    if (int'(mem_address) - BASE == dir_wait_row) wait_left = 5;
                    else wait_left = (ws_max > 0) ? int'($urandom_range(ws_max)) : 0;
                end
                if (wait_left > 0) begin
                    mem_waitrequest = 1;
                    wait_left--;
                    exp_extra++;
                    exp_stalls++;
                    prev_wait = 1;
                end else begin
                    mem_waitrequest = 0;
                    req_seen = 0;
                    rsp_row  = int'(mem_address) - BASE;
                    rsp_cnt  = (lat_max > 1) ? int'($urandom_range(lat_max, 1)) : 1;
                    exp_extra += rsp_cnt - 1;
                end
            end else begin
                mem_waitrequest = 1'($urandom_range(1));
            end

            fifo_full = '0;
            for (int r = 0; r < NR; r++)
                if (full_pct > 0 && $urandom_range(99) < full_pct) fifo_full[r] = 1;
            if (dir_full_left > 0 && active_row == 2 && rx[2].size() == 4) begin
                fifo_full[2] = 1;
                dir_full_left--;
            end
            if (active_row >= 0 && rx[active_row].size() < BPW && fifo_full[active_row]) begin
                exp_extra++;
                exp_stalls++;
            end

            #1;
            if (fill_active && busy) busy_cnt++;
            legal = ($countones(fifo_wren) <= 1) && ((fifo_wren & fifo_full) == '0);
            check("wren_legal", 64'(legal), 64'(1));
            for (int r = 0; r < NR; r++)
                if (fifo_wren[r]) rx[r].push_back(fifo_wdata);
            if (active_row >= 0 && rx[active_row].size() >= BPW) active_row = -1;
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic load_mem(input bit rnd);
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < BPW; k++)
                mem[r][k*DW +: DW] = rnd ? DW'($urandom) : DW'(r * 16 + k);
    endtask

    task automatic cfg(input int ws, input int lat, input int fp, input int sp);
        ws_max = ws; lat_max = lat; full_pct = fp; spur_pct = sp;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read"},  64'(mem_read), 64'(0));
        check({tag, "_addr"},  64'(mem_address), 64'(BASE));
        check({tag, "_wren"},  64'(fifo_wren), 64'(0));
        check({tag, "_wdata"}, 64'(fifo_wdata), 64'(0));
        check({tag, "_busy"},  64'(busy), 64'(0));
        check({tag, "_done"},  64'(done), 64'(0));
`ifdef FIFO_FILL_STALL_CNT_EN
        check({tag, "_stall"}, 64'(stall_cycles), 64'(0));
`endif
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 0;
            #2;
            check("idle_wren", 64'(fifo_wren), 64'(0));
            check("idle_busy", 64'(busy), 64'(0));
        end
    endtask

    task automatic do_fill(input bit spam, input int abort_row, output bit aborted);
        int exp_lat;
        logic [WW-1:0] got;
        @(negedge clk);
        start = 1;
        start_cyc = cyc; busy_cnt = 0; reads = 0; exp_extra = 0; exp_stalls = 0;
        done_seen = 0; fill_active = 1;
        for (int r = 0; r < NR; r++) rx[r].delete();
        aborted = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = spam && ($urandom_range(3) == 0);
            #2;
            if (done_seen) break;
            if (abort_row >= 0 && rx[abort_row].size() >= 2) begin
                aborted = 1;
                break;
            end
        end
        fill_active = 0;
        if (aborted) return;
        check("done_seen", 64'(done_seen), 64'(1));
        exp_lat = 2 + NR * (2 + BPW) + exp_extra;
        check("fill_latency", 64'(done_cyc - start_cyc + 1), 64'(exp_lat));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_lat - 1));
        check("read_count", 64'(reads), 64'(NR));
        for (int r = 0; r < NR; r++) begin
            got = '0;
            check($sformatf("row%0d_count", r), 64'(rx[r].size()), 64'(BPW));
            for (int k = 0; k < BPW && k < rx[r].size(); k++) got[k*DW +: DW] = rx[r][k];
            check($sformatf("row%0d_data", r), 64'(got), 64'(mem[r]));
        end
`ifdef FIFO_FILL_STALL_CNT_EN
        check("stall_cycles", 64'(stall_cycles), 64'(exp_stalls));
`endif
    endtask

    initial begin
        bit ab;
        rst_n = 0; start = 0;
        mem_waitrequest = 0; mem_readdatavalid = 0; mem_readdata = '0; fifo_full = '0;
        dir_wait_row = -1; dir_full_left = 0;
        cfg(0, 1, 0, 0);
        load_mem(0);
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1;
        idle_gap(3);

        // zero-wait fill, then done must be a single-cycle pulse
        do_fill(0, -1, ab);
        @(negedge clk);
        start = 0;
        #1;
        check("done_width", 64'(done), 64'(0));
        check("busy_after_done", 64'(busy), 64'(0));

        // five wait states on row 3
        dir_wait_row = 3;
        do_fill(0, -1, ab);
        dir_wait_row = -1;
        idle_gap(2);

        // FIFO 2 full for three cycles at byte 4
        dir_full_left = 3;
        do_fill(0, -1, ab);
        idle_gap(2);

        // start spammed while busy, then restarted the cycle after done
        load_mem(1);
        do_fill(1, -1, ab);
        do_fill(0, -1, ab);

        // spurious readdatavalid while idle
        cfg(0, 1, 0, 50);
        idle_gap(10);

        // reset during row 5 writes, then a clean fill
        cfg(1, 2, 10, 30);
        do_fill(0, 5, ab);
        check("reached_row5", 64'(ab), 64'(1));
        rst_n = 0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1;
        idle_gap(5);
        load_mem(1);
        do_fill(0, -1, ab);

        // randomised fills with stalls, latency and spurious valids
        for (int t = 0; t < 6; t++) begin
            cfg(3, 4, 30, 20);
            load_mem(1);
            do_fill(1'($urandom_range(1)), -1, ab);
            idle_gap(int'($urandom_range(3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
